div_unit_pipe_rdx: RTL

DIV_UNIT_PIPE_RDX -- requirements
Module: div_unit_pipe_rdx

---
 rtl/div_unit_pipe_rdx.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/div_unit_pipe_rdx.sv
// Iterative radix-2^BPC restoring divider with signed/unsigned and word-op support.
// One request in flight; result is held in registers until the consumer takes it.
//
// state  | meaning
// S_IDLE | ready to accept a request
// S_CALC | BPC shift-subtract steps per cycle
// S_DONE | result valid, waiting for resp_ready_i
module div_unit_pipe_rdx #(
    parameter int XLEN = 64,
    parameter int BPC  = 4
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            kill_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            op_32_i,
    input  logic            signed_i,
    input  logic [XLEN-1:0] dvnd_i,
    input  logic [XLEN-1:0] dvsr_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] quo_o,
    output logic [XLEN-1:0] rmd_o,
    output logic            busy_o
);

    localparam int CNT_W = $clog2(XLEN/BPC + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   dq_q, rem_q, dvs_q, quo_q, rmd_q;
    logic              op32_q, neg_q_q, neg_r_q;

    logic              accept;
    logic [XLEN-1:0]   a_ext, b_ext, a_abs, b_abs, dvnd_w;
    logic              a_neg, b_neg, dvsr_zero, ovf;

    logic [XLEN-1:0]   dq_n, rem_n, q_neg, r_neg, q_fix, r_fix;
    logic [XLEN:0]     rsh, diff;

    assign accept = req_valid_i & req_ready_o;

    // Operands normalised to XLEN: word ops sign- or zero-extend the low half.
    always_comb begin
        if (op_32_i) begin
            a_ext  = signed_i ? XLEN'($signed(dvnd_i[31:0])) : XLEN'(dvnd_i[31:0]);
            b_ext  = signed_i ? XLEN'($signed(dvsr_i[31:0])) : XLEN'(dvsr_i[31:0]);
            dvnd_w = XLEN'($signed(dvnd_i[31:0]));
        end else begin
            a_ext  = dvnd_i;
            b_ext  = dvsr_i;
            dvnd_w = dvnd_i;
        end
        a_neg     = signed_i & a_ext[XLEN-1];
        b_neg     = signed_i & b_ext[XLEN-1];
        a_abs     = a_neg ? -a_ext : a_ext;
        b_abs     = b_neg ? -b_ext : b_ext;
        dvsr_zero = (b_ext == '0);
        ovf       = signed_i && (b_ext == '1) &&
                    (op_32_i ? (dvnd_i[31:0] == 32'h8000_0000)
                             : (dvnd_i == {1'b1, {(XLEN-1){1'b0}}}));
    end

    // BPC restoring steps; quotient bits shift into dq from the LSB.
    always_comb begin
        dq_n  = dq_q;
        rem_n = rem_q;
        rsh   = '0;
        diff  = '0;
        for (int i = 0; i < BPC; i++) begin
            rsh  = {rem_n, dq_n[XLEN-1]};
            diff = rsh - {1'b0, dvs_q};
            if (!diff[XLEN]) begin
                rem_n = diff[XLEN-1:0];
                dq_n  = {dq_n[XLEN-2:0], 1'b1};
            end else begin
                rem_n = rsh[XLEN-1:0];
                dq_n  = {dq_n[XLEN-2:0], 1'b0};
            end
        end
        q_neg = neg_q_q ? -dq_n : dq_n;
        r_neg = neg_r_q ? -rem_n : rem_n;
        q_fix = op32_q ? XLEN'($signed(q_neg[31:0])) : q_neg;
        r_fix = op32_q ? XLEN'($signed(r_neg[31:0])) : r_neg;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = (dvsr_zero || ovf) ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            S_DONE: if (resp_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (kill_i) state_d = S_IDLE;
    end

    always_comb begin
        req_ready_o  = (state_q == S_IDLE) && !kill_i;
        resp_valid_o = (state_q == S_DONE);
        busy_o       = (state_q != S_IDLE);
        quo_o        = quo_q;
        rmd_o        = rmd_q;
    end

    // Result registers are only non-zero while in S_DONE.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q   <= '0;
            dq_q    <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            op32_q  <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (kill_i) begin
            cnt_q <= '0;
            quo_q <= '0;
            rmd_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    op32_q  <= op_32_i;
                    neg_q_q <= a_neg ^ b_neg;
                    neg_r_q <= a_neg;
                    dvs_q   <= b_abs;
                    dq_q    <= op_32_i ? (a_abs << (XLEN-32)) : a_abs;
                    rem_q   <= '0;
                    cnt_q   <= op_32_i ? CNT_W'(32/BPC) : CNT_W'(XLEN/BPC);
                    if (dvsr_zero) begin
                        quo_q <= '1;
                        rmd_q <= dvnd_w;
                    end else if (ovf) begin
                        quo_q <= dvnd_w;
                        rmd_q <= '0;
                    end
                end
                S_CALC: begin
                    dq_q  <= dq_n;
                    rem_q <= rem_n;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        quo_q <= q_fix;
                        rmd_q <= r_fix;
                    end
                end
                S_DONE: if (resp_ready_i) begin
                    quo_q <= '0;
                    rmd_q <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
